// File: rtl/alu_multicycle_if.sv
// Execute-stage ALU bus: one request per start, results qualified by a one-cycle valid.
// The master drives start/a/b/cin/ALUControl; the slave returns busy, valid and the registered results.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [3:0]       ALUControl;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic [3:0]       ALUFlags;
    logic [3:0]       FlagMask;

    modport master (
        output start, a, b, cin, ALUControl,
        input  busy, valid, Result, ResultHi, ALUFlags, FlagMask
    );

    modport slave (
        input  start, a, b, cin, ALUControl,
        output busy, valid, Result, ResultHi, ALUFlags, FlagMask
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered WIDTH-bit ALU with carry-in arithmetic and an iterative shift-add multiplier.
// Single-cycle ops return in 1 cycle; MUL/UMULL hold busy for WIDTH cycles before valid.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_multicycle_if.slave bus,
    output logic [1:0]      dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: start is taken at a rising edge only while busy=0; valid pulses for one
    // cycle when Result/ResultHi/ALUFlags/FlagMask change, and they hold until the next valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic                 umull_q;

    logic                 valid_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     result_hi_q;
    logic [3:0]           flags_q;
    logic [3:0]           mask_q;

    logic                 is_mul;
    logic                 arith;
    logic [WIDTH-1:0]     x, y;
    logic                 c0;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     s_res;
    logic [3:0]           s_flags;
    logic [3:0]           s_mask;

    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic                 last;
    logic [WIDTH-1:0]     m_res;
    logic [WIDTH-1:0]     m_hi;
    logic [3:0]           m_flags;

    assign is_mul = (bus.ALUControl[3:1] == 3'b100);

    // Single-cycle datapath: x/y/c0 are the real adder inputs, so V is taken from them directly.
    always_comb begin
        x       = '0;
        y       = '0;
        c0      = 1'b0;
        arith   = 1'b1;
        s_res   = '0;
        s_flags = 4'b0000;
        s_mask  = 4'b0000;
        case (bus.ALUControl)
            4'b0000: begin x = bus.a; y = bus.b;  c0 = 1'b0;    end
            4'b0001: begin x = bus.a; y = ~bus.b; c0 = 1'b1;    end
            4'b0101: begin x = bus.a; y = bus.b;  c0 = bus.cin; end
            4'b0110: begin x = bus.a; y = ~bus.b; c0 = bus.cin; end
            4'b0111: begin x = bus.b; y = ~bus.a; c0 = 1'b1;    end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c0};
        if (arith) begin
            s_res   = sum[WIDTH-1:0];
            s_mask  = 4'b1111;
            s_flags = {sum[WIDTH-1], ~|sum[WIDTH-1:0], sum[WIDTH],
                       (x[WIDTH-1] == y[WIDTH-1]) && (x[WIDTH-1] != sum[WIDTH-1])};
        end else begin
            case (bus.ALUControl)
                4'b0010: begin s_res = bus.a & bus.b; s_mask = 4'b1100; end
                4'b0011: begin s_res = bus.a | bus.b; s_mask = 4'b1100; end
                4'b0100: begin s_res = bus.a ^ bus.b; s_mask = 4'b1100; end
                default: begin s_res = '0;            s_mask = 4'b0000; end
            endcase
            if (s_mask[3]) s_flags = {s_res[WIDTH-1], ~|s_res, 2'b00};
        end
    end

    // One multiplier bit per cycle; acc_nxt already includes this cycle's partial product.
    always_comb begin
        addend  = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << count) : '0;
        acc_nxt = acc + addend;
        last    = (count == CW'(WIDTH - 1));
        m_res   = acc_nxt[WIDTH-1:0];
        if (umull_q) begin
            m_hi    = acc_nxt[2*WIDTH-1:WIDTH];
            m_flags = {acc_nxt[2*WIDTH-1], ~|acc_nxt, 2'b00};
        end else begin
            m_hi    = '0;
            m_flags = {acc_nxt[WIDTH-1], ~|acc_nxt[WIDTH-1:0], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start && is_mul) state_nxt = S_MUL;
            S_MUL:   if (last)                state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state == S_MUL);
        bus.valid    = valid_q;
        bus.Result   = result_q;
        bus.ResultHi = result_hi_q;
        bus.ALUFlags = flags_q;
        bus.FlagMask = mask_q;
        dbg_state    = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= 4'b0000;
            mask_q      <= 4'b0000;
            count       <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            umull_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (is_mul) begin
                            mcand   <= bus.a;
                            mplier  <= bus.b;
                            umull_q <= bus.ALUControl[0];
                            acc     <= '0;
                            count   <= '0;
                        end else begin
                            result_q    <= s_res;
                            result_hi_q <= '0;
                            flags_q     <= s_flags;
                            mask_q      <= s_mask;
                            valid_q     <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last) begin
                        result_q    <= m_res;
                        result_hi_q <= m_hi;
                        flags_q     <= m_flags;
                        mask_q      <= 4'b1100;
                        valid_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle at WIDTH=32 and WIDTH=8: directed vectors, an arithmetic reference
// model with an expected queue per instance, and a per-cycle compare of every output.
module tb_alu_multicycle;

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic [3:0]  fl;
    logic [3:0]  mk;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  logic [1:0] st32, st8;
  int cyc;
  int vectors;
  int miscompares;

  exp_t q32[$];
  exp_t q8[$];
  int   free_c[2];
  exp_t last_e[2];

  alu_multicycle_if #(.WIDTH(32)) b32 ();
  alu_multicycle_if #(.WIDTH(8))  b8 ();

  alu_multicycle #(.WIDTH(32)) u32 (.clk(clk), .reset(rst), .bus(b32), .dbg_state(st32));
  alu_multicycle #(.WIDTH(8))  u8  (.clk(clk), .reset(rst), .bus(b8),  .dbg_state(st8));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: plain integer arithmetic on the operation definitions
  function automatic exp_t model(input int w, input logic [3:0] op, input logic [63:0] ua_i,
                                 input logic [63:0] ub_i, input bit cin);
    exp_t e;
    longint ua, ub, m, half, sa, sb, sv, full, ci;
    logic [63:0] mm, prod, res, hi;
    bit c, v, arith;
    ua = longint'(ua_i); ub = longint'(ub_i); ci = longint'(cin);
    m = (longint'(1) << w) - 1; mm = 64'(m);
    half = longint'(1) << (w - 1);
    sa = (ua >= half) ? ua - (m + 1) : ua;
    sb = (ub >= half) ? ub - (m + 1) : ub;
    res = '0; hi = '0; c = 1'b0; v = 1'b0; sv = 0; arith = 1'b1; full = 0;
    e = '{default: 0};
    case (op)
      4'd0: begin full = ua + ub; res = 64'(full) & mm; c = (full > m); sv = sa + sb; end
      4'd1: begin res = 64'(ua - ub) & mm; c = (ua >= ub); sv = sa - sb; end
      4'd5: begin full = ua + ub + ci; res = 64'(full) & mm; c = (full > m); sv = sa + sb + ci; end
      4'd6: begin res = 64'(ua - ub - 1 + ci) & mm; c = (ua + ci >= ub + 1); sv = sa - sb - 1 + ci; end
      4'd7: begin res = 64'(ub - ua) & mm; c = (ub >= ua); sv = sb - sa; end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      v = (sv > half - 1) || (sv < -half);
      e.mk = 4'b1111;
      e.fl = {res[w-1], (res == 64'd0), c, v};
    end else begin
      prod = ua_i * ub_i;
      case (op)
        4'd2: begin res = ua_i & ub_i; e.mk = 4'b1100; e.fl = {res[w-1], (res == 64'd0), 2'b00}; end
        4'd3: begin res = ua_i | ub_i; e.mk = 4'b1100; e.fl = {res[w-1], (res == 64'd0), 2'b00}; end
        4'd4: begin res = ua_i ^ ub_i; e.mk = 4'b1100; e.fl = {res[w-1], (res == 64'd0), 2'b00}; end
        4'd8: begin res = prod & mm; e.mk = 4'b1100; e.fl = {res[w-1], (res == 64'd0), 2'b00}; end
        4'd9: begin
          res = prod & mm; hi = (prod >> w) & mm; e.mk = 4'b1100;
          e.fl = {hi[w-1], (prod == 64'd0), 2'b00};
        end
        default: begin res = '0; e.mk = 4'b0000; e.fl = 4'b0000; end
      endcase
    end
    e.res = res;
    e.hi  = hi;
    return e;
  endfunction

  task automatic pin(input string nm, input int w, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input bit cin, input logic [63:0] er,
                     input logic [63:0] eh, input logic [3:0] ef, input logic [3:0] em);
    exp_t e;
    e = model(w, op, a, b, cin);
    chk({nm, " res"}, e.res, er);
    chk({nm, " hi"}, e.hi, eh);
    chk({nm, " flags"}, 64'(e.fl), 64'(ef));
    chk({nm, " mask"}, 64'(e.mk), 64'(em));
  endtask

  // scoreboard: acceptance at the rising edge, comparison at the falling edge
  task automatic accept(input int d, input int w, input bit r, input bit s, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b, input bit cin);
    exp_t e;
    bit   ismul;
    if (r) begin
      if (d == 0) q32.delete(); else q8.delete();
      free_c[d] = 0;
      last_e[d] = '{default: 0};
    end else if (s && cyc >= free_c[d]) begin
      e = model(w, op, a, b, cin);
      ismul = (op == 4'd8) || (op == 4'd9);
      e.due = cyc + (ismul ? w : 0);
      free_c[d] = cyc + (ismul ? w + 1 : 1);
      if (d == 0) q32.push_back(e); else q8.push_back(e);
    end
  endtask

  task automatic check(input int d, input int w, input logic dv, input logic db,
                       input logic [63:0] r, input logic [63:0] h, input logic [3:0] f,
                       input logic [3:0] m);
    bit   ev;
    exp_t e;
    string p;
    p = $sformatf("w%0d", w);
    e = '{default: 0};
    if (d == 0) begin
      ev = (q32.size() > 0) && (q32[0].due == cyc);
      if (ev) e = q32.pop_front();
    end else begin
      ev = (q8.size() > 0) && (q8[0].due == cyc);
      if (ev) e = q8.pop_front();
    end
    chk({p, " valid"}, 64'(dv), 64'(ev));
    if (ev) last_e[d] = e;
    chk({p, " busy"}, 64'(db), 64'(cyc <= free_c[d] - 2));
    chk({p, " Result"}, r, last_e[d].res);
    chk({p, " ResultHi"}, h, last_e[d].hi);
    chk({p, " ALUFlags"}, 64'(f), 64'(last_e[d].fl));
    chk({p, " FlagMask"}, 64'(m), 64'(last_e[d].mk));
  endtask

  initial begin
    bit r;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      r = rst;
      accept(0, 32, r, b32.start, b32.ALUControl, 64'(b32.a), 64'(b32.b), b32.cin);
      accept(1, 8, r, b8.start, b8.ALUControl, 64'(b8.a), 64'(b8.b), b8.cin);
      @(negedge clk);
      check(0, 32, b32.valid, b32.busy, 64'(b32.Result), 64'(b32.ResultHi), b32.ALUFlags, b32.FlagMask);
      check(1, 8, b8.valid, b8.busy, 64'(b8.Result), 64'(b8.ResultHi), b8.ALUFlags, b8.FlagMask);
    end
  end

  // driver tasks
  task automatic issue(input int d, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input bit cin);
    @(posedge clk);
    #1;
    if (d == 0) begin
      b32.start = 1'b1; b32.ALUControl = op; b32.a = a[31:0]; b32.b = b[31:0]; b32.cin = cin;
      b8.start = 1'b0;
    end else begin
      b8.start = 1'b1; b8.ALUControl = op; b8.a = a[7:0]; b8.b = b[7:0]; b8.cin = cin;
      b32.start = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    b32.start = 1'b0;
    b8.start  = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int n;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    b32.start = 1'b0; b32.a = '0; b32.b = '0; b32.cin = 1'b0; b32.ALUControl = 4'd0;
    b8.start  = 1'b0; b8.a  = '0; b8.b  = '0; b8.cin  = 1'b0; b8.ALUControl  = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    pin("pin add", 32, 4'd0, 64'h7FFFFFFF, 64'h1, 1'b0, 64'h80000000, 64'h0, 4'b1001, 4'b1111);
    pin("pin sub0", 32, 4'd1, 64'h5, 64'h5, 1'b0, 64'h0, 64'h0, 4'b0110, 4'b1111);
    pin("pin sub1", 32, 4'd1, 64'h0, 64'h1, 1'b0, 64'hFFFFFFFF, 64'h0, 4'b1000, 4'b1111);
    pin("pin rsb", 32, 4'd7, 64'h3, 64'hA, 1'b0, 64'h7, 64'h0, 4'b0010, 4'b1111);
    pin("pin adc", 32, 4'd5, 64'hFFFFFFFF, 64'h0, 1'b1, 64'h0, 64'h0, 4'b0110, 4'b1111);
    pin("pin sbc", 32, 4'd6, 64'h5, 64'h3, 1'b0, 64'h1, 64'h0, 4'b0010, 4'b1111);
    pin("pin and", 32, 4'd2, 64'hF0F0F0F0, 64'h0FF00000, 1'b0, 64'h00F00000, 64'h0, 4'b0000, 4'b1100);
    pin("pin umull", 32, 4'd9, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 64'h1, 64'hFFFFFFFE, 4'b1000, 4'b1100);
    pin("pin mul", 32, 4'd8, 64'h10000, 64'h10000, 1'b0, 64'h0, 64'h0, 4'b0100, 4'b1100);
    pin("pin w8 add0", 8, 4'd0, 64'hFF, 64'h01, 1'b0, 64'h00, 64'h0, 4'b0110, 4'b1111);
    pin("pin w8 add1", 8, 4'd0, 64'h40, 64'h40, 1'b0, 64'h80, 64'h0, 4'b1001, 4'b1111);

    // single-cycle ops back to back
    issue(0, 4'd0, 64'h7FFFFFFF, 64'h1, 1'b0);
    issue(0, 4'd1, 64'h5, 64'h5, 1'b0);
    issue(0, 4'd1, 64'h0, 64'h1, 1'b0);
    issue(0, 4'd7, 64'h3, 64'hA, 1'b0);
    issue(0, 4'd5, 64'hFFFFFFFF, 64'h0, 1'b1);
    issue(0, 4'd6, 64'h5, 64'h3, 1'b0);
    issue(0, 4'd2, 64'hF0F0F0F0, 64'h0FF00000, 1'b0);
    issue(0, 4'd3, 64'h80000000, 64'h00000001, 1'b0);
    issue(0, 4'd4, 64'hA5A5A5A5, 64'hA5A5A5A5, 1'b1);
    issue(0, 4'd6, 64'h80000000, 64'h1, 1'b1);
    issue(0, 4'd5, 64'h7FFFFFFF, 64'h0, 1'b1);
    issue(0, 4'd0, 64'h12345678, 64'h0F0F0F0F, 1'b1);
    issue(0, 4'hC, 64'h1, 64'h2, 1'b0);
    idle(3);

    // UMULL with an ignored start mid-flight and a start in the valid cycle
    issue(0, 4'd9, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0);
    @(posedge clk);
    #1 b32.start = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) begin b32.start = 1'b1; b32.ALUControl = 4'd0; b32.a = 32'd1; b32.b = 32'd1; end
      if (i == 6) b32.start = 1'b0;
      if (b32.valid) begin n = i; break; end
    end
    chk("umull valid cycle", 64'(n), 64'd33);
    chk("umull Result", 64'(b32.Result), 64'h00000001);
    chk("umull ResultHi", 64'(b32.ResultHi), 64'hFFFFFFFE);
    b32.start = 1'b1; b32.ALUControl = 4'd0; b32.a = 32'd2; b32.b = 32'd3; b32.cin = 1'b0;
    idle(3);

    issue(0, 4'd8, 64'h10000, 64'h10000, 1'b0);
    idle(34);
    issue(0, 4'd8, 64'h7, 64'h6, 1'b0);
    idle(34);
    issue(0, 4'd9, 64'h12345678, 64'h9ABCDEF0, 1'b0);
    idle(34);
    issue(0, 4'd8, 64'hFFFFFFFF, 64'h2, 1'b0);
    idle(34);

    // reset in cycle 10 of a multiply
    issue(0, 4'd9, 64'hDEADBEEF, 64'h3, 1'b0);
    @(posedge clk);
    #1 b32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset Result", 64'(b32.Result), 64'h0);
    chk("reset valid", 64'(b32.valid), 64'h0);
    chk("reset busy", 64'(b32.busy), 64'h0);
    repeat (40) @(posedge clk);
    issue(0, 4'd0, 64'h11111111, 64'h22222222, 1'b0);
    idle(3);

    // 8-bit instance, one issue per cycle
    issue(1, 4'd0, 64'hFF, 64'h01, 1'b0);
    issue(1, 4'd0, 64'h40, 64'h40, 1'b0);
    issue(1, 4'd1, 64'h7F, 64'h80, 1'b0);
    issue(1, 4'd7, 64'h01, 64'h00, 1'b0);
    issue(1, 4'd5, 64'h80, 64'h80, 1'b1);
    issue(1, 4'd4, 64'h3C, 64'hC3, 1'b0);
    issue(1, 4'd9, 64'hFF, 64'hFF, 1'b0);
    idle(12);
    issue(1, 4'd8, 64'h0F, 64'h11, 1'b0);
    idle(12);

    chk("drain w32", 64'(q32.size()), 64'd0);
    chk("drain w8", 64'(q8.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
